// File: rtl/alu_pkg.sv
// Shared types for multicycle_alu: opcodes, FSM states, flag register layout
// and the encoding of shift kinds handed to the iterative unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_CMP   = 4'd5,
        OP_MOV   = 4'd6,
        OP_RSV7  = 4'd7,
        OP_SLL   = 4'd8,
        OP_ROL   = 4'd9,
        OP_SRL   = 4'd10,
        OP_SRA   = 4'd11,
        OP_MUL   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_HLT   = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic s;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Shift kinds are the low two opcode bits of the 8..11 group.
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_ROL = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    function automatic logic is_shift_op(input opcode_t op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative one-bit-per-cycle shifter, plus a shift-add multiplier when
// MULTICYCLE_ALU_MUL_EN is defined. done is high during the final iteration.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_shift,
    input  logic [1:0]       shift_kind,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] shift_src,
`ifdef MULTICYCLE_ALU_MUL_EN
    input  logic             start_mul,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             high_nonzero,
`endif
    output logic [WIDTH-1:0] result,
    output logic             last_out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [1:0]       kind;
    logic [WIDTH-1:0] part;
    logic             last_bit;
    logic [WIDTH-1:0] step_part;
    logic             step_last;
`ifdef MULTICYCLE_ALU_MUL_EN
    logic             is_mul;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH:0]   sum;
`endif

    // Value of the partial result after the current iteration; the final
    // iteration's value is exported so the caller can capture it on that edge.
    always_comb begin
        step_part = part;
        step_last = last_bit;
`ifdef MULTICYCLE_ALU_MUL_EN
        step_hi = hi;
        sum     = {1'b0, hi} + (part[0] ? {1'b0, mcand} : '0);
        if (is_mul) begin
            step_hi   = sum[WIDTH:1];
            step_part = {sum[0], part[WIDTH-1:1]};
        end else
`endif
        begin
            case (kind)
                SH_SLL: begin
                    step_part = {part[WIDTH-2:0], 1'b0};
                    step_last = part[WIDTH-1];
                end
                SH_ROL: begin
                    step_part = {part[WIDTH-2:0], part[WIDTH-1]};
                    step_last = part[WIDTH-1];
                end
                SH_SRL: begin
                    step_part = {1'b0, part[WIDTH-1:1]};
                    step_last = part[0];
                end
                default: begin
                    step_part = {part[WIDTH-1], part[WIDTH-1:1]};
                    step_last = part[0];
                end
            endcase
        end
    end

    assign done     = busy && (count == CW'(1));
    assign result   = step_part;
    assign last_out = step_last;
`ifdef MULTICYCLE_ALU_MUL_EN
    assign high_nonzero = |step_hi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            count    <= '0;
            kind     <= SH_SLL;
            part     <= '0;
            last_bit <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
            is_mul   <= 1'b0;
            hi       <= '0;
            mcand    <= '0;
`endif
        end else if (start_shift) begin
            busy     <= 1'b1;
            count    <= CW'(amount);
            kind     <= shift_kind;
            part     <= shift_src;
            last_bit <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
            is_mul   <= 1'b0;
        end else if (start_mul) begin
            busy     <= 1'b1;
            is_mul   <= 1'b1;
            count    <= CW'(WIDTH);
            part     <= mul_b;
            hi       <= '0;
            mcand    <= mul_a;
            last_bit <= 1'b0;
`endif
        end else if (busy) begin
            part     <= step_part;
            last_bit <= step_last;
            count    <= count - 1'b1;
`ifdef MULTICYCLE_ALU_MUL_EN
            hi       <= step_hi;
`endif
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked multicycle ALU: single-cycle arithmetic/logic, iterative shifts,
// and an iterative multiplier when MULTICYCLE_ALU_MUL_EN is defined.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             S,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             HLT
);

    state_t           state;
    state_t           next_state;
    opcode_t          op;
    flags_t           flags;
    flags_t           sc_flags;
    flags_t           iter_flags;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] sc_out;
    logic [WIDTH-1:0] sz_src;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             sc_flag_we;
    logic             hlt_reg;
    logic             accept;
    logic             start_shift;
    logic [WIDTH-1:0] iter_result;
    logic             iter_last;
    logic             iter_done;
`ifdef MULTICYCLE_ALU_MUL_EN
    logic             start_mul;
    logic             iter_hi_nz;
`endif

    assign op        = opcode_t'(opcode);
    assign in_ready  = (state == ST_IDLE) && !hlt_reg;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign out       = out_reg;
    assign S         = flags.s;
    assign Z         = flags.z;
    assign C         = flags.c;
    assign V         = flags.v;
    assign HLT       = hlt_reg;

    assign sum  = {1'b0, in1} + {1'b0, in2};
    assign diff = {1'b0, in1} - {1'b0, in2};

    // Single-cycle results; shifts reach here only with d = 0, and every
    // opcode without an architectural result leaves the flags untouched.
    always_comb begin
        sc_out     = '0;
        sc_flag_we = 1'b1;
        sc_flags   = '0;
        case (op)
            OP_ADD: begin
                sc_out     = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_out     = (op == OP_CMP) ? in1 : diff[WIDTH-1:0];
                sc_flags.c = diff[WIDTH];
                sc_flags.v = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: sc_out = in1 & in2;
            OP_OR:  sc_out = in1 | in2;
            OP_XOR: sc_out = in1 ^ in2;
            OP_MOV, OP_SLL, OP_ROL, OP_SRL, OP_SRA: sc_out = in2;
            default: sc_flag_we = 1'b0;
        endcase
        sz_src     = (op == OP_CMP) ? diff[WIDTH-1:0] : sc_out;
        sc_flags.s = sz_src[WIDTH-1];
        sc_flags.z = (sz_src == '0);
    end

    always_comb begin
        iter_flags   = '0;
        iter_flags.s = iter_result[WIDTH-1];
        iter_flags.z = (iter_result == '0);
        iter_flags.c = iter_last;
`ifdef MULTICYCLE_ALU_MUL_EN
        if (state == ST_MUL) begin
            iter_flags.c = iter_hi_nz;
            iter_flags.v = iter_hi_nz;
        end
`endif
    end

    always_comb begin
        next_state  = state;
        start_shift = 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
        start_mul   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift_op(op) && (d != '0)) begin
                        start_shift = 1'b1;
                        next_state  = ST_SHIFT;
                    end
`ifdef MULTICYCLE_ALU_MUL_EN
                    else if (op == OP_MUL) begin
                        start_mul  = 1'b1;
                        next_state = ST_MUL;
                    end
`endif
                    else begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_SHIFT, ST_MUL: begin
                if (iter_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            out_reg <= '0;
            flags   <= '0;
            hlt_reg <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_DONE) begin
                out_reg <= sc_out;
                if (sc_flag_we) begin
                    flags <= sc_flags;
                end
                if (op == OP_HLT) begin
                    hlt_reg <= 1'b1;
                end
            end else if (iter_done && (state == ST_SHIFT || state == ST_MUL)) begin
                out_reg <= iter_result;
                flags   <= iter_flags;
            end
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk          (clk),
        .rst          (rst),
        .start_shift  (start_shift),
        .shift_kind   (opcode[1:0]),
        .amount       (d),
        .shift_src    (in2),
`ifdef MULTICYCLE_ALU_MUL_EN
        .start_mul    (start_mul),
        .mul_a        (in1),
        .mul_b        (in2),
        .high_nonzero (iter_hi_nz),
`endif
        .result       (iter_result),
        .last_out     (iter_last),
        .done         (iter_done)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu with a cycle-level reference model.
// MUL expectations follow MULTICYCLE_ALU_MUL_EN as compiled.
module tb_multicycle_alu;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    typedef struct packed {
        logic [15:0] out;
        logic [3:0]  flags;
        logic        wr;
        logic        hlt;
        logic [7:0]  lat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        S, Z, C, V, HLT;

    int   checks = 0;
    int   errors = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    multicycle_alu #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in1       (in1),
        .in2       (in2),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .S         (S),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .HLT       (HLT)
    );

    // Architectural result of one operation, straight from the opcode table.
    function automatic res_t model_op(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [3:0] n);
        res_t        r;
        logic [31:0] w;
        longint      sa, sb, t;
        logic        c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        r.wr = 1'b1;
        r.lat = 8'd1;
        c = 1'b0;
        v = 1'b0;
        w = '0;
        t = 0;
        case (op)
            4'd0: begin
                w = 32'(a) + 32'(b);
                r.out = w[15:0];
                c = w[16];
                t = sa + sb;
                v = (t > 32767) || (t < -32768);
            end
            4'd1, 4'd5: begin
                r.out = a - b;
                c = (a < b);
                t = sa - sb;
                v = (t > 32767) || (t < -32768);
            end
            4'd2: r.out = a & b;
            4'd3: r.out = a | b;
            4'd4: r.out = a ^ b;
            4'd6: r.out = b;
            4'd8, 4'd9, 4'd10, 4'd11: begin
                r.lat = 8'(n) + 8'd1;
                if (n == 4'd0) begin
                    r.out = b;
                end else begin
                    case (op)
                        4'd8: begin
                            w = {16'h0, b} << n;
                            r.out = w[15:0];
                            c = w[16];
                        end
                        4'd9: begin
                            w = {b, b} << n;
                            r.out = w[31:16];
                            c = r.out[0];
                        end
                        4'd10: begin
                            w = {b, 16'h0} >> n;
                            r.out = w[31:16];
                            c = w[15];
                        end
                        default: begin
                            w = $signed({b, 16'h0}) >>> n;
                            r.out = w[31:16];
                            c = w[15];
                        end
                    endcase
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            4'd12: begin
                w = 32'(a) * 32'(b);
                r.out = w[15:0];
                c = |w[31:16];
                v = c;
                r.lat = 8'd17;
            end
`endif
            4'd15: begin
                r.wr = 1'b0;
                r.hlt = 1'b1;
            end
            default: r.wr = 1'b0;
        endcase
        r.flags = {r.out[15], r.out == 16'h0, c, v};
        if (op == 4'd5) begin
            r.out = a;
        end
        return r;
    endfunction

    res_t        cur;
    res_t        pend;
    logic        m_ready;
    logic        m_valid;
    logic        m_hlt;
    logic [15:0] m_out;
    logic [3:0]  m_flags;
    int          m_wait;

    always_comb cur = model_op(opcode, in1, in2, d);

    // Reference timing: a result becomes visible lat-1 edges after acceptance.
    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_hlt   <= 1'b0;
            m_out   <= '0;
            m_flags <= '0;
            m_wait  <= 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_ready <= !m_hlt;
            end
        end else if (m_wait > 1) begin
            m_wait <= m_wait - 1;
        end else if (m_wait == 1) begin
            m_wait  <= 0;
            m_valid <= 1'b1;
            m_out   <= pend.out;
            if (pend.wr) m_flags <= pend.flags;
            if (pend.hlt) m_hlt <= 1'b1;
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            pend    <= cur;
            if (cur.lat == 8'd1) begin
                m_valid <= 1'b1;
                m_out   <= cur.out;
                if (cur.wr) m_flags <= cur.flags;
                if (cur.hlt) m_hlt <= 1'b1;
            end else begin
                m_wait <= int'(cur.lat) - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cycle in_ready", 32'(in_ready), 32'(m_ready));
            check("cycle out_valid", 32'(out_valid), 32'(m_valid));
            check("cycle flags", 32'({S, Z, C, V}), 32'(m_flags));
            check("cycle HLT", 32'(HLT), 32'(m_hlt));
            if (m_valid) check("cycle out", 32'(out), 32'(m_out));
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] n, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept timeout", 32'(in_ready), 32'd1);
        opcode = op;
        in1 = a;
        in2 = b;
        d = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] e_out, input logic [3:0] e_flags,
                               input int e_lat, input int lat);
        check({name, " latency"}, 32'(lat), 32'(e_lat));
        check({name, " out"}, 32'(out), 32'(e_out));
        check({name, " flags"}, 32'({S, Z, C, V}), 32'(e_flags));
        check({name, " model out"}, 32'(m_out), 32'(e_out));
        check({name, " model flags"}, 32'(m_flags), 32'(e_flags));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [3:0]  v_op [8] = '{4'd0, 4'd4, 4'd9, 4'd10, 4'd12, 4'd7, 4'd3, 4'd6};
    logic [15:0] v_a  [8] = '{16'hFFFF, 16'h0F0F, 16'h0000, 16'h0000, 16'h1234, 16'h1111, 16'h00F0, 16'hABCD};
    logic [15:0] v_b  [8] = '{16'h0001, 16'hFF00, 16'h8001, 16'h00F0, 16'h0011, 16'h2222, 16'h0F00, 16'h0000};
    logic [3:0]  v_n  [8] = '{4'd0, 4'd0, 4'd15, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};

    initial begin
        int lat;
        res_t e;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opcode = '0;
        in1 = '0;
        in2 = '0;
        d = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset flags", 32'({S, Z, C, V}), 32'd0);
        check("reset HLT", 32'(HLT), 32'd0);
        check_en = 1'b1;
        rst = 1'b0;

        applyStimulus(4'd0, 16'h7FFF, 16'h0001, 4'd0, lat);
        checkOutput("add overflow", 16'h8000, 4'b1001, 1, lat);
        consume();
        applyStimulus(4'd1, 16'h0000, 16'h0001, 4'd0, lat);
        checkOutput("sub borrow", 16'hFFFF, 4'b1010, 1, lat);
        consume();
        applyStimulus(4'd5, 16'h1234, 16'h1234, 4'd0, lat);
        checkOutput("cmp equal", 16'h1234, 4'b0100, 1, lat);
        consume();
        applyStimulus(4'd11, 16'h5555, 16'h8008, 4'd4, lat);
        checkOutput("sra d4", 16'hF800, 4'b1010, 5, lat);
        consume();
        applyStimulus(4'd8, 16'h5555, 16'hA5A5, 4'd0, lat);
        checkOutput("sll d0", 16'hA5A5, 4'b1000, 1, lat);
        consume();
        applyStimulus(4'd12, 16'h0100, 16'h0100, 4'd0, lat);
`ifdef MULTICYCLE_ALU_MUL_EN
        checkOutput("mul", 16'h0000, 4'b0111, 17, lat);
`else
        checkOutput("mul absent", 16'h0000, 4'b1000, 1, lat);
`endif
        consume();

        for (int i = 0; i < 8; i++) begin
            e = model_op(v_op[i], v_a[i], v_b[i], v_n[i]);
            applyStimulus(v_op[i], v_a[i], v_b[i], v_n[i], lat);
            check("vector latency", 32'(lat), 32'(e.lat));
            consume();
        end

        // Result must hold while writeback stalls.
        applyStimulus(4'd9, 16'h0000, 16'h8001, 4'd1, lat);
        checkOutput("rol d1", 16'h0003, 4'b0010, 2, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall out", 32'(out), 32'h0003);
            check("stall flags", 32'({S, Z, C, V}), 32'b0010);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
        end
        consume();

        @(negedge clk);
        opcode = 4'd10;
        in1 = 16'h0000;
        in2 = 16'hFFFF;
        d = 4'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid shift out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort flags", 32'({S, Z, C, V}), 32'd0);
        check("abort out", 32'(out), 32'd0);
        rst = 1'b0;

        applyStimulus(4'd1, 16'h0001, 16'h0002, 4'd0, lat);
        checkOutput("sub neg", 16'hFFFF, 4'b1010, 1, lat);
        consume();
        applyStimulus(4'd15, 16'h1234, 16'h5678, 4'd0, lat);
        checkOutput("halt", 16'h0000, 4'b1010, 1, lat);
        check("halt HLT", 32'(HLT), 32'd1);
        consume();
        opcode = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halted in_ready", 32'(in_ready), 32'd0);
            check("halted out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("unhalt HLT", 32'(HLT), 32'd0);
        check("unhalt in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        applyStimulus(4'd0, 16'h0001, 16'h0001, 4'd0, lat);
        checkOutput("add after halt", 16'h0002, 4'b0000, 1, lat);
        consume();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
